scalar_mem_responder: RTL
=========================

# scalar_mem_responder

Memory-side responder for the 8-bit scalar processor bus (`addr`, `rd`, `wrt`, bidirectional `dat`). It holds a 256×8 unified instruction/data store and answers processor fetches and RDM reads within the same cycle. It captures WRM writes on the clock edge that ends the write cycle. It also provides a host load port for program preload, a write-protected program region, a sticky bus-error flag and access counters for the bench.

## Interface
- `DEPTH`, 256: number of memory bytes; address width is fixed at 8.
- `ROM_TOP`, 8'h40: addresses `0..ROM_TOP-1` are write-protected from the processor bus; the host port may still write them.
- `CNT_W`, 16: width of the access counters.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  reset, synchronous, active-low.
- `addr`  in  8  processor address.
- `rd`  in  1  processor read strobe.
- `wrt`  in  1  processor write strobe.
- `dat`  inout  8  shared data bus; driven by this block only while `rd=1 && wrt=0`.
- `ld_valid`  in  1  host load request.
- `ld_addr`  in  8  host load address.
- `ld_data`  in  8  host load byte.
- `ld_ready`  out  1  host load accepted this cycle.
- `err`  out  1  sticky bus error.
- `err_code`  out  2  first error cause: 01 = rd&wrt contention, 10 = protected write, 11 = both in the same cycle.
- `rd_count`  out  CNT_W  completed read transactions, saturating.
- `wr_count`  out  CNT_W  accepted processor writes, saturating.

## Operation
- Bus FSM states: `B_IDLE`, `B_READ`, `B_WRITE`, `B_LOAD`.
- Each posedge with `rst=1`, the next state is chosen from the sampled inputs:
  - `rd && wrt` → `B_IDLE`, error 01.
  - `rd` → `B_READ`.
  - `wrt` → `B_WRITE`.
  - `ld_valid` → `B_LOAD`.
  - otherwise → `B_IDLE`.
- Reads are asynchronous. `dat = mem[addr]` combinationally while `rd=1 && wrt=0`; otherwise `dat` is 8'hzz.
- One read transaction is a contiguous run of `rd=1` cycles (the processor holds `rd` for 2 cycles per fetch or RDM).
  - `rd_count` increments once, on the first cycle of the run, i.e. on the transition into `B_READ` from any other state.
- Writes: on a posedge sampling `wrt=1 && rd=0`:
  - If `addr >= ROM_TOP`: `mem[addr] <= dat` and `wr_count` increments.
  - Otherwise the write is dropped and error 10 is raised.
- Host load is accepted only when `rd=0 && wrt=0 && ld_valid=1` in the same cycle.
  - `ld_ready` is combinational: `ld_valid & ~rd & ~wrt`.
  - On an accepted load, `mem[ld_addr] <= ld_data` at that posedge, with no protection check.
  - The processor always has priority; a rejected load must be held by the host.
- Errors:
  - `err` sets on the first error and stays set until reset.
  - `err_code` latches the cause of the first error only; later errors do not change it.
  - During `rd && wrt` contention, `dat` is not driven and no write occurs.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset at posedge with `rst=0`: state `B_IDLE`, `err=0`, `err_code=00`, `rd_count=0`, `wr_count=0`.
  - `ld_ready` and `dat` follow their combinational rules; `dat` is high-Z unless `rd=1 && wrt=0`.
  - Memory contents are not reset.
- Read latency is 0 cycles. Data is valid in the same cycle as `rd`/`addr` and is sampled by the processor at the following edge.
- Write latency is 1 edge. Data is visible to a read starting in the cycle after the capturing edge.
- Read of the same address in the cycle after a write returns the new byte.
- Reset mid-transaction:
  - Any write or load sampled at the reset edge is discarded.
  - The counters clear at that edge, even if a read run is in progress.
- Address wrap does not apply: `addr` covers the full 256-byte space. For `DEPTH<256`, out-of-range reads return 8'h00 and out-of-range writes are dropped without an error.

## Structure
- Shared package `scalar_bus_pkg` holds:
  - bus state enum (`B_IDLE`..`B_LOAD`);
  - `err_code` constants;
  - opcode constants `NOP`..`CFR`, reused by the bench program image.
- One sub-module `scalar_mem_array`: 256×8 storage with asynchronous read and a single synchronous write port. The top-level muxes the host and processor write requests into that port.

## Test plan
- Host load of 8'h10 at 8'h00 and 8'h90 at 8'h01, then processor `rd=1, addr=8'h01` → `dat=8'h90` in the same cycle; `rd_count=1` after a 2-cycle `rd` run.
- Processor write `addr=8'h80, dat=8'h5A, wrt=1` for one cycle, then `rd` at 8'h80 → `dat=8'h5A`; `wr_count=1`.
- Processor write to 8'h20 (below `ROM_TOP`) with 8'hFF → memory unchanged, `err=1`, `err_code=10`; a later contention cycle leaves `err_code=10`.
- `rd=1, wrt=1` at `addr=8'h80` → `dat` high-Z, no write, `err_code=01`.
- `ld_valid=1` while `wrt=1` → `ld_ready=0` and no load; the next idle cycle gives `ld_ready=1` and the byte is stored.
- Reset asserted in the capture cycle of a write to 8'h81 → 8'h81 is unchanged, counters are 0, `err=0`.

Source files
------------

// File: rtl/scalar_bus_pkg.sv
// Shared definitions for the 8-bit scalar processor bus: bus states, error codes, opcodes.
package scalar_bus_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_READ  = 2'd1,
        B_WRITE = 2'd2,
        B_LOAD  = 2'd3
    } bus_state_e;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_CONTENTION = 2'b01;
    localparam logic [1:0] ERR_PROTECT    = 2'b10;
    localparam logic [1:0] ERR_BOTH       = 2'b11;

    // Opcode field occupies the upper nibble of an instruction byte.
    localparam logic [OP_W-1:0] NOP = 4'h0;
    localparam logic [OP_W-1:0] LDI = 4'h1;
    localparam logic [OP_W-1:0] ADD = 4'h2;
    localparam logic [OP_W-1:0] SUB = 4'h3;
    localparam logic [OP_W-1:0] XRL = 4'h4;
    localparam logic [OP_W-1:0] JMP = 4'h5;
    localparam logic [OP_W-1:0] JZ  = 4'h6;
    localparam logic [OP_W-1:0] RDM = 4'h7;
    localparam logic [OP_W-1:0] WRM = 4'h8;
    localparam logic [OP_W-1:0] CFR = 4'h9;

endpackage

// File: rtl/scalar_mem_responder_if.sv
// Processor strobes/address and host load port of the scalar memory responder.
interface scalar_mem_responder_if;
    import scalar_bus_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wrt;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;

    modport master (output addr, rd, wrt, ld_valid, ld_addr, ld_data, input  ld_ready);
    modport slave  (input  addr, rd, wrt, ld_valid, ld_addr, ld_data, output ld_ready);
endinterface

// File: rtl/scalar_mem_array.sv
// Byte storage with asynchronous read and one synchronous write port; out-of-range reads return 0.
module scalar_mem_array
    import scalar_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem[IDX_W'(waddr)] <= wdata;
        end
    end

    assign rdata = (32'(raddr) < DEPTH) ? mem[IDX_W'(raddr)] : '0;
endmodule

// File: rtl/scalar_mem_responder.sv
// Memory-side responder: same-cycle reads, edge-captured writes, host preload, protection, counters.
module scalar_mem_responder
    import scalar_bus_pkg::*;
#(
    parameter int unsigned       DEPTH   = 256,
    parameter logic [ADDR_W-1:0] ROM_TOP = 8'h40,
    parameter int unsigned       CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    scalar_mem_responder_if.slave  bus,
    inout  wire  [DATA_W-1:0]      dat,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [CNT_W-1:0]       rd_count,
    output logic [CNT_W-1:0]       wr_count
);
    bus_state_e        state, state_nxt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rdata;
    logic              err_set;
    logic [1:0]        err_cause;
    logic              wr_inc;
    logic              rd_inc;
    logic              contention;
    logic              protected_wr;
    logic              in_range;

    assign contention   = bus.rd & bus.wrt;
    assign protected_wr = bus.wrt & (bus.addr < ROM_TOP);
    assign in_range     = 32'(bus.addr) < DEPTH;
    assign bus.ld_ready = bus.ld_valid & ~bus.rd & ~bus.wrt;
    assign dat          = (bus.rd && !bus.wrt) ? rdata : 'z;

    scalar_mem_array #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we & rst),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (bus.addr),
        .rdata (rdata)
    );

    // State, sticky error and saturating counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= B_IDLE;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            state <= state_nxt;
            if (err_set && !err) begin
                err      <= 1'b1;
                err_code <= err_cause;
            end
            if (rd_inc && (rd_count != '1)) rd_count <= rd_count + CNT_W'(1);
            if (wr_inc && (wr_count != '1)) wr_count <= wr_count + CNT_W'(1);
        end
    end

    // Next state and write-port arbitration; the processor always beats the host.
    always_comb begin
        state_nxt = B_IDLE;
        mem_we    = 1'b0;
        mem_waddr = bus.addr;
        mem_wdata = dat;
        err_set   = 1'b0;
        err_cause = ERR_NONE;
        wr_inc    = 1'b0;
        if (contention) begin
            err_set   = 1'b1;
            err_cause = protected_wr ? ERR_BOTH : ERR_CONTENTION;
        end else if (bus.rd) begin
            state_nxt = B_READ;
        end else if (bus.wrt) begin
            state_nxt = B_WRITE;
            if (protected_wr) begin
                err_set   = 1'b1;
                err_cause = ERR_PROTECT;
            end else if (in_range) begin
                mem_we = 1'b1;
                wr_inc = 1'b1;
            end
        end else if (bus.ld_valid) begin
            state_nxt = B_LOAD;
            mem_we    = 1'b1;
            mem_waddr = bus.ld_addr;
            mem_wdata = bus.ld_data;
        end
        rd_inc = (state_nxt == B_READ) && (state != B_READ);
    end
endmodule
